// File: rtl/dds_cfg_icb_master_pkg.sv
// Shared DDS definitions: memory-bus widths, DDS register map and the
// configuration master's state encoding.
package dds_cfg_icb_master_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_MASK_W = MEM_DATA_W / 8;

    localparam logic [MEM_ADDR_W-1:0] DDS_OFS_AMP   = 32'h0000_0000;
    localparam logic [MEM_ADDR_W-1:0] DDS_OFS_FREQ  = 32'h0000_0004;
    localparam logic [MEM_ADDR_W-1:0] DDS_OFS_MIN   = 32'h0000_0008;
    localparam logic [MEM_ADDR_W-1:0] DDS_OFS_PHASE = 32'h0000_000c;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR_CMD = 3'd1,
        ST_RD_CMD = 3'd2,
        ST_RD_RSP = 3'd3,
        ST_DONE   = 3'd4
    } cfg_state_e;

    function automatic logic [MEM_ADDR_W-1:0] reg_offset(input logic [1:0] idx);
        case (idx)
            2'd0:    reg_offset = DDS_OFS_AMP;
            2'd1:    reg_offset = DDS_OFS_FREQ;
            2'd2:    reg_offset = DDS_OFS_MIN;
            default: reg_offset = DDS_OFS_PHASE;
        endcase
    endfunction

endpackage

// File: rtl/dds_cfg_icb_master.sv
// Writes the four DDS configuration registers over ICB and optionally reads
// them back, flagging a mismatch, bus error or response timeout in err.
module dds_cfg_icb_master
    import dds_cfg_icb_master_pkg::*;
#(
    parameter logic [MEM_ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [7:0]            RSP_TIMEOUT = 8'd255
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  start,
    input  logic                  verify_en,
    input  logic [8:0]            amp_in,
    input  logic [31:0]           freq_in,
    input  logic [31:0]           min_in,
    input  logic [11:0]           phase_in,
    output logic                  icb_cmd_valid,
    input  logic                  icb_cmd_ready,
    output logic [MEM_ADDR_W-1:0] icb_cmd_addr,
    output logic                  icb_cmd_read,
    output logic [MEM_DATA_W-1:0] icb_cmd_wdata,
    output logic [MEM_MASK_W-1:0] icb_cmd_wmask,
    input  logic                  icb_rsp_valid,
    output logic                  icb_rsp_ready,
    input  logic                  icb_rsp_err,
    input  logic [MEM_DATA_W-1:0] icb_rsp_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output cfg_state_e            state_dbg
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; the command fields stay stable from valid rising until that edge.
    cfg_state_e            state;
    logic [1:0]            idx;
    logic [1:0]            idx_nxt;
    logic [7:0]            tmo_cnt;
    logic                  verify_q;
    logic [MEM_DATA_W-1:0] cfg_regs [4];

    assign idx_nxt       = idx + 2'd1;
    assign icb_cmd_wmask = '1;
    assign state_dbg     = state;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state         <= ST_IDLE;
            idx           <= 2'd0;
            tmo_cnt       <= 8'd0;
            verify_q      <= 1'b0;
            for (int i = 0; i < 4; i++) cfg_regs[i] <= '0;
            icb_cmd_valid <= 1'b0;
            icb_cmd_read  <= 1'b0;
            icb_cmd_addr  <= '0;
            icb_cmd_wdata <= '0;
            icb_rsp_ready <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        cfg_regs[0]   <= {23'd0, amp_in};
                        cfg_regs[1]   <= freq_in;
                        cfg_regs[2]   <= min_in;
                        cfg_regs[3]   <= {20'd0, phase_in};
                        verify_q      <= verify_en;
                        err           <= 1'b0;
                        idx           <= 2'd0;
                        busy          <= 1'b1;
                        icb_cmd_valid <= 1'b1;
                        icb_cmd_read  <= 1'b0;
                        icb_cmd_addr  <= BASE_ADDR + reg_offset(2'd0);
                        icb_cmd_wdata <= {23'd0, amp_in};
                        state         <= ST_WR_CMD;
                    end
                end
                ST_WR_CMD: begin
                    if (icb_cmd_ready) begin
                        idx           <= idx_nxt;
                        icb_cmd_addr  <= BASE_ADDR + reg_offset(idx_nxt);
                        icb_cmd_wdata <= cfg_regs[idx_nxt];
                        if (idx == 2'd3) begin
                            if (verify_q) begin
                                icb_cmd_read <= 1'b1;
                                state        <= ST_RD_CMD;
                            end else begin
                                icb_cmd_valid <= 1'b0;
                                busy          <= 1'b0;
                                done          <= 1'b1;
                                state         <= ST_DONE;
                            end
                        end
                    end
                end
                ST_RD_CMD: begin
                    if (icb_cmd_ready) begin
                        icb_cmd_valid <= 1'b0;
                        icb_rsp_ready <= 1'b1;
                        tmo_cnt       <= 8'd0;
                        state         <= ST_RD_RSP;
                    end
                end
                ST_RD_RSP: begin
                    if (icb_rsp_valid) begin
                        if (icb_rsp_err || (icb_rsp_rdata != cfg_regs[idx])) err <= 1'b1;
                        icb_rsp_ready <= 1'b0;
                        idx           <= idx_nxt;
                        if (idx == 2'd3) begin
                            icb_cmd_read <= 1'b0;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                            state        <= ST_DONE;
                        end else begin
                            icb_cmd_valid <= 1'b1;
                            icb_cmd_addr  <= BASE_ADDR + reg_offset(idx_nxt);
                            icb_cmd_wdata <= cfg_regs[idx_nxt];
                            state         <= ST_RD_CMD;
                        end
                    end else if (tmo_cnt == RSP_TIMEOUT - 8'd1) begin
                        // Silent responder: abandon the remaining reads.
                        err           <= 1'b1;
                        icb_rsp_ready <= 1'b0;
                        icb_cmd_read  <= 1'b0;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        state         <= ST_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dds_cfg_icb_master.sv
// Directed bench: a DDS register slave model answers the ICB master while a
// scoreboard checks every command handshake and done pulse against expectations.
module tb_dds_cfg_icb_master;
    import dds_cfg_icb_master_pkg::*;

    localparam logic [31:0] TB_BASE = 32'h0000_0000;
    localparam int          XW      = 65;

    // Clock / reset
    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    logic        start     = 1'b0;
    logic        verify_en = 1'b0;
    logic [8:0]  amp_in    = '0;
    logic [31:0] freq_in   = '0;
    logic [31:0] min_in    = '0;
    logic [11:0] phase_in  = '0;

    logic        icb_cmd_valid;
    logic        icb_cmd_ready = 1'b0;
    logic [31:0] icb_cmd_addr;
    logic        icb_cmd_read;
    logic [31:0] icb_cmd_wdata;
    logic [3:0]  icb_cmd_wmask;
    logic        icb_rsp_valid = 1'b0;
    logic        icb_rsp_ready;
    logic        icb_rsp_err   = 1'b0;
    logic [31:0] icb_rsp_rdata = '0;
    logic        busy;
    logic        done;
    logic        err;
    cfg_state_e  state_dbg;

    dds_cfg_icb_master #(
        .BASE_ADDR   (TB_BASE),
        .RSP_TIMEOUT (8'd255)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .start         (start),
        .verify_en     (verify_en),
        .amp_in        (amp_in),
        .freq_in       (freq_in),
        .min_in        (min_in),
        .phase_in      (phase_in),
        .icb_cmd_valid (icb_cmd_valid),
        .icb_cmd_ready (icb_cmd_ready),
        .icb_cmd_addr  (icb_cmd_addr),
        .icb_cmd_read  (icb_cmd_read),
        .icb_cmd_wdata (icb_cmd_wdata),
        .icb_cmd_wmask (icb_cmd_wmask),
        .icb_rsp_valid (icb_rsp_valid),
        .icb_rsp_ready (icb_rsp_ready),
        .icb_rsp_err   (icb_rsp_err),
        .icb_rsp_rdata (icb_rsp_rdata),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .state_dbg     (state_dbg)
    );

    // Scoreboard state
    logic [XW-1:0] exp_q[$];   // {read, addr, wdata}
    logic [32:0]   done_q[$];  // {err, cycle of done pulse}
    int n_checks = 0;
    int n_fail   = 0;

    // Slave behaviour knobs (driven by the stimulus process only)
    bit stall_mode = 1'b0;
    int rsp_mode   = 0;        // 0 echo, 1 corrupt phase readback, 2 silent
    bit spurious   = 1'b0;

    logic [31:0]   mem [4];
    int            stall_cnt = 0;
    bit            rd_pend   = 1'b0;
    logic [1:0]    rd_idx    = '0;
    bit            prev_stall = 1'b0;
    logic [XW-1:0] prev_cmd  = '0;
    int            rd_hs_cyc = 0;
    int            last_done_cyc = 0;

    task automatic check(input bit ok, input string name, input logic [64:0] act, input logic [64:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Slave model and monitor: drives inputs at negedge, then checks the
    // handshake that the next rising edge will complete.
    always @(negedge sys_clk) begin
        logic [XW-1:0] cur;
        logic [XW-1:0] e;
        logic [32:0]   d;
        if (!sys_rst_n) begin
            rd_pend       = 1'b0;
            stall_cnt     = 0;
            prev_stall    = 1'b0;
            icb_cmd_ready = 1'b0;
            icb_rsp_valid = 1'b0;
            icb_rsp_err   = 1'b0;
            icb_rsp_rdata = '0;
        end else begin
            icb_rsp_valid = 1'b0;
            icb_rsp_err   = 1'b0;
            icb_rsp_rdata = '0;
            if (rd_pend && rsp_mode != 2) begin
                icb_rsp_valid = 1'b1;
                icb_rsp_rdata = (rsp_mode == 1 && rd_idx == 2'd3) ? 32'h0000_03FF : mem[rd_idx];
                rd_pend = 1'b0;
            end else if (spurious && !icb_rsp_ready) begin
                icb_rsp_valid = 1'b1;
                icb_rsp_err   = 1'b1;
                icb_rsp_rdata = 32'hDEAD_BEEF;
            end

            if (icb_cmd_valid) begin
                if (stall_mode && stall_cnt < 3) begin
                    icb_cmd_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    icb_cmd_ready = 1'b1;
                    stall_cnt = 0;
                end
            end else begin
                icb_cmd_ready = !stall_mode;
                stall_cnt = 0;
            end

            cur = {icb_cmd_read, icb_cmd_addr, icb_cmd_wdata};
            if (prev_stall)
                check(icb_cmd_valid && cur == prev_cmd, "cmd_hold_while_stalled", {icb_cmd_valid, cur[63:0]}, {1'b1, prev_cmd[63:0]});
            prev_stall = icb_cmd_valid && !icb_cmd_ready;
            prev_cmd   = cur;

            check(!(icb_cmd_valid && icb_rsp_ready), "single_outstanding", {icb_cmd_valid, icb_rsp_ready}, 65'd0);

            if (icb_cmd_valid && icb_cmd_ready) begin
                check(icb_cmd_wmask == 4'hF, "wmask", 65'(icb_cmd_wmask), 65'hF);
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_cmd", cur, '0);
                end else begin
                    e = exp_q.pop_front();
                    if (e[64])
                        check(cur[64:32] == e[64:32], "rd_cmd", 65'(cur[64:32]), 65'(e[64:32]));
                    else
                        check(cur == e, "wr_cmd", cur, e);
                end
                if (!icb_cmd_read) begin
                    mem[icb_cmd_addr[3:2]] = icb_cmd_wdata;
                end else begin
                    rd_pend   = 1'b1;
                    rd_idx    = icb_cmd_addr[3:2];
                    rd_hs_cyc = cyc;
                end
            end
        end

        if (done) begin
            last_done_cyc = cyc;
            if (done_q.size() == 0) begin
                check(1'b0, "unexpected_done", 65'(cyc), '0);
            end else begin
                d = done_q.pop_front();
                check(32'(cyc) == d[31:0], "done_cycle", 65'(cyc), 65'(d[31:0]));
                check(err == d[32], "err_at_done", 65'(err), 65'(d[32]));
                check(!busy, "busy_low_at_done", 65'(busy), 65'd0);
            end
        end
    end

    // Driver tasks
    task automatic next_cycle();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        check(icb_cmd_valid == 1'b0, {tag, "_cmd_valid"}, 65'(icb_cmd_valid), 65'd0);
        check(icb_cmd_read == 1'b0, {tag, "_cmd_read"}, 65'(icb_cmd_read), 65'd0);
        check(icb_cmd_addr == 32'd0, {tag, "_cmd_addr"}, 65'(icb_cmd_addr), 65'd0);
        check(icb_cmd_wdata == 32'd0, {tag, "_cmd_wdata"}, 65'(icb_cmd_wdata), 65'd0);
        check(icb_rsp_ready == 1'b0, {tag, "_rsp_ready"}, 65'(icb_rsp_ready), 65'd0);
        check({busy, done, err} == 3'b000, {tag, "_busy_done_err"}, 65'({busy, done, err}), 65'd0);
        check(state_dbg == ST_IDLE, {tag, "_state"}, 65'(state_dbg), 65'(ST_IDLE));
    endtask

    task automatic wait_drained(input int budget, input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0) && n < budget) begin
            next_cycle();
            n++;
        end
        check(exp_q.size() == 0 && done_q.size() == 0, {tag, "_drained"},
              65'(exp_q.size() + done_q.size()), 65'd0);
        exp_q.delete();
        done_q.delete();
        repeat (3) next_cycle();
    endtask

    task automatic run_cfg(input logic [8:0] a, input logic [31:0] f, input logic [31:0] m,
                           input logic [11:0] p, input bit ver, input int n_reads,
                           input bit exp_err, input int latency, input string tag);
        logic [31:0] dv [4];
        dv[0] = {23'd0, a};
        dv[1] = f;
        dv[2] = m;
        dv[3] = {20'd0, p};
        amp_in = a; freq_in = f; min_in = m; phase_in = p;
        verify_en = ver;
        start = 1'b1;
        for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, TB_BASE + 32'(k * 4), dv[k]});
        for (int k = 0; k < n_reads; k++) exp_q.push_back({1'b1, TB_BASE + 32'(k * 4), 32'd0});
        done_q.push_back({exp_err, 32'(cyc + latency)});
        next_cycle();
        start = 1'b0;
        verify_en = 1'b0;
        check(busy == 1'b1, {tag, "_busy_after_start"}, 65'(busy), 65'd1);
        check(err == 1'b0, {tag, "_err_cleared_on_start"}, 65'(err), 65'd0);
        wait_drained(latency + 20, tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst_n = 1'b0;
        repeat (3) next_cycle();
        check_reset_outputs("por");
        sys_rst_n = 1'b1;
        repeat (2) next_cycle();

        // Writes only, ready high, stray responses that must be ignored.
        spurious = 1'b1;
        run_cfg(9'd256, 32'd42949, 32'd0, 12'd1024, 1'b0, 0, 1'b0, 5, "wr_basic");
        spurious = 1'b0;

        // Three stall cycles on every command.
        stall_mode = 1'b1;
        run_cfg(9'd256, 32'd42949, 32'd0, 12'd1024, 1'b0, 0, 1'b0, 17, "wr_stall");
        stall_mode = 1'b0;

        // Readback against a matching register model.
        rsp_mode = 0;
        run_cfg(9'd256, 32'd42949, 32'd0, 12'd1024, 1'b1, 4, 1'b0, 13, "verify_ok");

        // Phase readback corrupted to 0x3FF.
        rsp_mode = 1;
        run_cfg(9'd256, 32'd42949, 32'd0, 12'd1024, 1'b1, 4, 1'b1, 13, "verify_bad");
        rsp_mode = 0;

        // Maximum-width values; also shows the sticky err cleared by this start.
        run_cfg(9'h1FF, 32'hFFFF_FFFF, 32'h8000_0001, 12'hFFF, 1'b1, 4, 1'b0, 13, "verify_max");

        // Silent responder: done rises 255 edges after the read handshake edge.
        rsp_mode = 2;
        run_cfg(9'd256, 32'd42949, 32'd0, 12'd1024, 1'b1, 1, 1'b1, 261, "timeout");
        check(last_done_cyc - rd_hs_cyc == 256, "timeout_from_rd_handshake",
              65'(last_done_cyc - rd_hs_cyc), 65'd256);
        sys_rst_n = 1'b0;
        next_cycle();
        sys_rst_n = 1'b1;
        rsp_mode = 0;
        repeat (2) next_cycle();

        // Start while busy is ignored; reset during the third write drops the sequence.
        stall_mode = 1'b1;
        amp_in = 9'd256; freq_in = 32'd42949; min_in = 32'd0; phase_in = 12'd1024;
        start = 1'b1;
        exp_q.push_back({1'b0, TB_BASE + 32'h0, 32'd256});
        exp_q.push_back({1'b0, TB_BASE + 32'h4, 32'd42949});
        next_cycle();
        start = 1'b0;
        next_cycle();
        amp_in = 9'd17; freq_in = 32'h5555_AAAA; min_in = 32'd99; phase_in = 12'd3;
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        repeat (7) next_cycle();
        check(icb_cmd_valid && icb_cmd_addr == TB_BASE + 32'h8 && state_dbg == ST_WR_CMD,
              "at_wr_idx2", {icb_cmd_valid, icb_cmd_addr}, {1'b1, TB_BASE + 32'h8});
        sys_rst_n = 1'b0;
        next_cycle();
        check_reset_outputs("mid_reset");
        next_cycle();
        sys_rst_n = 1'b1;
        stall_mode = 1'b0;
        repeat (30) next_cycle();
        check(exp_q.size() == 0, "writes_before_reset", 65'(exp_q.size()), 65'd0);
        check(state_dbg == ST_IDLE && !busy, "idle_after_reset", {state_dbg, busy}, {ST_IDLE, 1'b0});
        exp_q.delete();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dds_cfg_icb_master.md
DDS_CFG_ICB_MASTER -- requirements
Module: dds_cfg_icb_master

Interface
REQ-001 Parameter BASE_ADDR, 32'h0000_0000: base of the DDS register window; register offsets are 0x00 amp, 0x04 freq, 0x08 min, 0x0c phase.
REQ-002 Parameter RSP_TIMEOUT, 8'd255: maximum cycles to wait for a read response.
REQ-003 sys_clk  in  1  single clock; all logic on posedge; reset is synchronous and active-low.
REQ-004 sys_rst_n  in  1  synchronous active-low reset.
REQ-005 start  in  1  one-cycle request to begin a configuration sequence.
REQ-006 verify_en  in  1  when high at start, a readback phase follows the writes.
REQ-007 amp_in  in  9  amplitude value.
REQ-008 freq_in  in  32  frequency tuning word.
REQ-009 min_in  in  32  minimum-resolution value.
REQ-010 phase_in  in  12  phase offset.
REQ-011 icb_cmd_valid  out  1  command valid.
REQ-012 icb_cmd_ready  in  1  command accepted by the responder.
REQ-013 icb_cmd_addr  out  32  command address.
REQ-014 icb_cmd_read  out  1  1 = read, 0 = write.
REQ-015 icb_cmd_wdata  out  32  write data.
REQ-016 icb_cmd_wmask  out  4  write byte mask, always 4'hF.
REQ-017 icb_rsp_valid  in  1  response valid; write responses are not expected.
REQ-018 icb_rsp_ready  out  1  response ready.
REQ-019 icb_rsp_err  in  1  response error.
REQ-020 icb_rsp_rdata  in  32  read data.
REQ-021 busy  out  1  high from the cycle after an accepted start until DONE.
REQ-022 done  out  1  one-cycle pulse when the sequence ends.
REQ-023 err  out  1  sticky error flag; cleared by the next accepted start.

Function
REQ-024 FSM states: IDLE, WR_CMD, RD_CMD, RD_RSP, DONE; 2-bit register index idx selects the offset as idx*4.
REQ-025 IDLE: start=1 latches the four inputs zero-extended to 32 bits and latches verify_en; it also clears err and idx, then moves to WR_CMD.
REQ-026 start is ignored in every state other than IDLE.
REQ-027 WR_CMD: hold icb_cmd_valid=1, icb_cmd_read=0, addr=BASE_ADDR+idx*4 and wdata=latched[idx], stable until icb_cmd_ready=1.
REQ-028 A write completes on the cmd handshake cycle; on handshake idx increments, and at idx=3 the FSM goes to RD_CMD with idx=0 if verify is latched, else to DONE.
REQ-029 RD_CMD: hold icb_cmd_valid=1 and icb_cmd_read=1 with the same address until icb_cmd_ready=1, then move to RD_RSP and clear the timeout counter.
REQ-030 RD_RSP: icb_rsp_ready=1; on icb_rsp_valid, set err if icb_rsp_err=1 or rdata differs from latched[idx].
REQ-031 After a read response, idx increments and the FSM returns to RD_CMD; at idx=3 it goes to DONE.
REQ-032 RD_RSP timeout: after RSP_TIMEOUT cycles without icb_rsp_valid, set err and go to DONE, aborting the remaining reads.
REQ-033 An icb_rsp_valid arriving outside RD_RSP is ignored; icb_rsp_ready is 0 outside RD_RSP.
REQ-034 DONE: done=1 for exactly one cycle, then IDLE; busy=0 in IDLE and DONE.
REQ-035 The FSM asserts at most one outstanding transaction and never asserts icb_cmd_valid while in RD_RSP.

Reset
REQ-036 When sys_rst_n=0 at a clock edge, the FSM goes to IDLE, idx=0, and the timeout counter and latched registers clear to 0.
REQ-037 Output reset values are icb_cmd_valid=0, icb_cmd_read=0, icb_cmd_addr=0, icb_cmd_wdata=0, icb_rsp_ready=0, busy=0, done=0, err=0.
REQ-038 Reset mid-sequence abandons the transaction with no done pulse.

Structure
REQ-039 The register offsets, the state encoding and the 32-bit address/data widths belong in the shared DDS package, alongside the existing memory-bus width definitions.
REQ-040 The block is a single module with no sub-modules.

Verification
REQ-041 Start with amp=256, freq=42949, min=0, phase=1024, verify_en=0 and ready tied high -> four writes to 0x00/04/08/0c on consecutive cycles, done 5 cycles after start, err=0.
REQ-042 The same start with icb_cmd_ready low for 3 cycles on each command -> cmd fields are held stable while stalled, and writes occur in order.
REQ-043 verify_en=1 against a model DDS register slave -> four reads return matching data, done pulses, err=0.
REQ-044 verify_en=1 with the slave corrupting the phase readback (0x3FF) -> err=1 after done.
REQ-045 verify_en=1 with the slave never asserting rsp_valid -> err=1 and done exactly 255 cycles after the first read handshake.
REQ-046 start pulsed while busy, and reset asserted during WR_CMD idx=2 -> the second start is ignored; on reset, outputs are at reset values on the next cycle and no done pulse occurs.
